// File: rtl/fifo_512x16_wr_offset_pkg.sv
// Shared constants for the 512x16 offset-write packet FIFO.
// A packet is a fixed block of PKT_WORDS words addressed by a PKT_LOG-bit offset.
package fifo_512x16_wr_offset_pkg;

    localparam int PKT_WORDS = 16;
    localparam int PKT_LOG   = 4;
    localparam int FIFO_DW   = 16;

    typedef logic [PKT_LOG-1:0] pkt_off_t;

    // Slot counter must hold 0..2**n_log inclusive.
    function automatic int slot_cnt_w(input int n_log);
        return n_log + 1;
    endfunction

endpackage

// File: rtl/xil_mem_dp_512x16.sv
// Dual-port block RAM, single clock, byte write enables on both ports.
// Port 1 read data is registered and only updates when i_en1 is high.
module xil_mem_dp_512x16 #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic [DW/8-1:0] i_wen0,
    input  logic [AW-1:0]   i_addr0,
    input  logic [DW-1:0]   i_din0,
    input  logic            i_en1,
    input  logic [DW/8-1:0] i_wen1,
    input  logic [AW-1:0]   i_addr1,
    input  logic [DW-1:0]   i_din1,
    output logic [DW-1:0]   o_dout1
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DW/8; b++) begin
            if (i_wen0[b]) mem[i_addr0][b*8 +: 8] <= i_din0[b*8 +: 8];
        end
        if (i_en1) begin
            for (int b = 0; b < DW/8; b++) begin
                if (i_wen1[b]) mem[i_addr1][b*8 +: 8] <= i_din1[b*8 +: 8];
            end
            o_dout1 <= mem[i_addr1];
        end
    end

endmodule

// File: rtl/fifo_512x16_wr_offset.sv
// Packet FIFO: words are scattered into the slot under assembly at any offset,
// committed with i_wr_eop, then drained in commit order at offsets 0..15.
module fifo_512x16_wr_offset
    import fifo_512x16_wr_offset_pkg::*;
#(
    parameter int N_LOG = 5,
    parameter int DW    = FIFO_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_wr_data,
    input  logic [3:0]    i_wr_offset,
    input  logic          i_wr_en,
    input  logic          i_wr_eop,
    output logic          o_full,
    output logic [N_LOG:0] o_wr_packets,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_valid,
    output logic          o_rd_eop,
    output logic          o_empty
);

    localparam int CW = slot_cnt_w(N_LOG);
    localparam int AW = N_LOG + PKT_LOG;
    localparam logic [CW-1:0]    SLOTS    = CW'(1 << N_LOG);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [N_LOG-1:0] PTR_ONE  = N_LOG'(1);
    localparam pkt_off_t         OFF_ONE  = PKT_LOG'(1);
    localparam pkt_off_t         LAST_OFF = PKT_LOG'(PKT_WORDS - 1);

    logic [N_LOG-1:0] wr_ptr;
    logic [N_LOG-1:0] rd_ptr;
    pkt_off_t         rd_offset;
    logic [CW-1:0]    pkt_cnt;
    logic             rd_valid;
    logic             rd_eop;

    logic mem_wr_en;
    logic wr_commit;
    logic rd_fire;
    logic rd_free;

    // Valid/ready: writes and commits are accepted while o_full=0, reads while
    // o_empty=0; o_rd_valid qualifies o_rd_data/o_rd_eop for exactly one cycle.
    assign o_full       = (pkt_cnt == SLOTS);
    assign o_empty      = (pkt_cnt == '0);
    assign o_wr_packets = pkt_cnt;
    assign o_rd_valid   = rd_valid;
    assign o_rd_eop     = rd_eop;

    assign mem_wr_en = i_wr_en & ~o_full;
    assign wr_commit = i_wr_eop & ~o_full;
    assign rd_fire   = i_rd_en & ~o_empty;
    assign rd_free   = rd_fire & (rd_offset == LAST_OFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_offset <= '0;
            pkt_cnt   <= '0;
            rd_valid  <= 1'b0;
            rd_eop    <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            rd_eop   <= rd_free;
            if (wr_commit) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_fire)   rd_offset <= rd_offset + OFF_ONE;
            if (rd_free)   rd_ptr <= rd_ptr + PTR_ONE;
            // Commit and free in the same cycle cancel out.
            case ({wr_commit, rd_free})
                2'b10:   pkt_cnt <= pkt_cnt + CNT_ONE;
                2'b01:   pkt_cnt <= pkt_cnt - CNT_ONE;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // The read slot never equals the slot under assembly while writes are
    // accepted, so the two ports never collide on an address.
    xil_mem_dp_512x16 #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk     (clk),
        .i_wen0  ({(DW/8){mem_wr_en}}),
        .i_addr0 ({wr_ptr, i_wr_offset}),
        .i_din0  (i_wr_data),
        .i_en1   (rd_fire),
        .i_wen1  ({(DW/8){1'b0}}),
        .i_addr1 ({rd_ptr, rd_offset}),
        .i_din1  ({DW{1'b0}}),
        .o_dout1 (o_rd_data)
    );

endmodule

// File: tb/tb_fifo_512x16_wr_offset.sv
// Directed bench for fifo_512x16_wr_offset: a vector table for the basic
// packet round trip plus hand-written sequences for full, wrap and reset cases.
module tb_fifo_512x16_wr_offset;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_offset = '0;
    logic        wr_en = 1'b0;
    logic        wr_eop = 1'b0;
    logic        full;
    logic [5:0]  wr_packets;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_eop;
    logic        empty;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [3:0]  off;
        logic [15:0] data;
        logic        eop;
        logic        re;
        logic        e_empty;
        logic [5:0]  e_cnt;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_eop;
    } vec_t;

    vec_t tbl[34];

    fifo_512x16_wr_offset dut (
        .clk          (clk),
        .rst          (rst),
        .i_wr_data    (wr_data),
        .i_wr_offset  (wr_offset),
        .i_wr_en      (wr_en),
        .i_wr_eop     (wr_eop),
        .o_full       (full),
        .o_wr_packets (wr_packets),
        .i_rd_en      (rd_en),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid),
        .o_rd_eop     (rd_eop),
        .o_empty      (empty)
    );

    // clock
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic [3:0] off, input logic [15:0] data,
                                input logic eop, input logic re, input logic e_empty,
                                input logic [5:0] e_cnt, input logic e_valid,
                                input logic [15:0] e_data, input logic e_eop);
        vec_t v;
        v.we = we; v.off = off; v.data = data; v.eop = eop; v.re = re;
        v.e_empty = e_empty; v.e_cnt = e_cnt; v.e_valid = e_valid;
        v.e_data = e_data; v.e_eop = e_eop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // driver: hold inputs for one clock, outputs are sampled 1ns after the edge
    task automatic cyc(input logic we, input logic [3:0] off, input logic [15:0] d,
                       input logic eop, input logic re);
        wr_en = we; wr_offset = off; wr_data = d; wr_eop = eop; rd_en = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0; wr_eop = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".empty"}, 32'(empty), 32'd1);
        chk({nm, ".full"}, 32'(full), 32'd0);
        chk({nm, ".cnt"}, 32'(wr_packets), 32'd0);
        chk({nm, ".valid"}, 32'(rd_valid), 32'd0);
        chk({nm, ".eop"}, 32'(rd_eop), 32'd0);
    endtask

    initial begin
        logic [15:0] pkt [16];
        logic [15:0] d;
        logic [15:0] got;
        logic [3:0]  off;
        logic        we;
        logic        eop;
        logic        re;
        int          wp;
        int          wi;
        int          rd_word;
        int          pkts_read;
        int          cyc_n;

        // table: descending scatter of one packet, commit, drain, idle
        for (int i = 0; i < 16; i++)
            tbl[i] = mk(1'b1, 4'(15 - i), 16'(16'hA000 + 15 - i), 1'b0, 1'b0,
                        1'b1, 6'd0, 1'b0, 16'h0, 1'b0);
        tbl[16] = mk(1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 1'b0, 6'd1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 16; k++)
            tbl[17 + k] = mk(1'b0, 4'd0, 16'h0, 1'b0, 1'b1, (k == 15),
                             (k == 15) ? 6'd0 : 6'd1, 1'b1, 16'(16'hA000 + k), (k == 15));
        tbl[33] = mk(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 16'h0, 1'b0);

        do_reset();
        chk_idle("reset");

        for (int i = 0; i < 34; i++) begin
            cyc(tbl[i].we, tbl[i].off, tbl[i].data, tbl[i].eop, tbl[i].re);
            chk($sformatf("t1[%0d].empty", i), 32'(empty), 32'(tbl[i].e_empty));
            chk($sformatf("t1[%0d].cnt", i), 32'(wr_packets), 32'(tbl[i].e_cnt));
            chk($sformatf("t1[%0d].valid", i), 32'(rd_valid), 32'(tbl[i].e_valid));
            chk($sformatf("t1[%0d].eop", i), 32'(rd_eop), 32'(tbl[i].e_eop));
            if (tbl[i].e_valid)
                chk($sformatf("t1[%0d].data", i), 32'(rd_data), 32'(tbl[i].e_data));
        end

        // write and commit in the same cycle
        do_reset();
        cyc(1'b1, 4'd15, 16'h55AA, 1'b1, 1'b0);
        chk("t2.cnt", 32'(wr_packets), 32'd1);
        chk("t2.empty", 32'(empty), 32'd0);
        for (int k = 0; k < 16; k++) cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        chk("t2.data15", 32'(rd_data), 32'h55AA);
        chk("t2.eop15", 32'(rd_eop), 32'd1);
        chk("t2.cnt_after", 32'(wr_packets), 32'd0);

        // fill all 32 slots, overflow attempt, then free one
        do_reset();
        for (int p = 0; p < 32; p++) cyc(1'b1, 4'd0, 16'(16'hC000 + p), 1'b1, 1'b0);
        chk("t3.full", 32'(full), 32'd1);
        chk("t3.cnt", 32'(wr_packets), 32'd32);
        cyc(1'b1, 4'd0, 16'hDEAD, 1'b1, 1'b0);
        chk("t3.cnt_ovf", 32'(wr_packets), 32'd32);
        chk("t3.full_ovf", 32'(full), 32'd1);
        cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        chk("t3.slot0_word0", 32'(rd_data), 32'hC000);
        for (int k = 1; k < 15; k++) cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        chk("t3.full_w14", 32'(full), 32'd1);
        cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        chk("t3.full_w15", 32'(full), 32'd0);
        chk("t3.cnt_w15", 32'(wr_packets), 32'd31);
        chk("t3.eop_w15", 32'(rd_eop), 32'd1);

        // commit concurrent with free keeps the count
        do_reset();
        for (int p = 0; p < 3; p++) cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        chk("t4.cnt3", 32'(wr_packets), 32'd3);
        for (int k = 0; k < 15; k++) cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
        chk("t4.cnt_same", 32'(wr_packets), 32'd3);
        chk("t4.eop", 32'(rd_eop), 32'd1);
        cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
        chk("t4.cnt_hold", 32'(wr_packets), 32'd3);

        // 40 packets streamed through with scrambled offsets and random reads
        do_reset();
        wp = 0; wi = 0; rd_word = 0; pkts_read = 0; cyc_n = 0;
        while ((wp < 40 || exp_q.size() != 0) && cyc_n < 3000) begin
            we = 1'b0; eop = 1'b0; off = '0; d = '0;
            if (wp < 40 && !full) begin
                off = 4'((wi * 7 + wp) % 16);
                d = 16'($urandom_range(0, 65535));
                pkt[off] = d;
                we = 1'b1;
                eop = (wi == 15);
                if (wi == 15) begin
                    for (int k = 0; k < 16; k++) exp_q.push_back(pkt[k]);
                    wp++;
                    wi = 0;
                end else begin
                    wi++;
                end
            end
            re = ($urandom_range(0, 3) != 0);
            cyc(we, off, d, eop, re);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL t5.extra_word: got %0h expected none", rd_data);
                end else begin
                    got = exp_q.pop_front();
                    chk($sformatf("t5.data p%0d w%0d", pkts_read, rd_word), 32'(rd_data), 32'(got));
                    chk($sformatf("t5.eop p%0d w%0d", pkts_read, rd_word), 32'(rd_eop), 32'(rd_word == 15));
                    if (rd_word == 15) pkts_read++;
                    rd_word = (rd_word + 1) % 16;
                end
            end
            cyc_n++;
        end
        chk("t5.timeout", 32'(cyc_n < 3000), 32'd1);
        chk("t5.pkts_read", 32'(pkts_read), 32'd40);
        chk("t5.empty", 32'(empty), 32'd1);

        // async reset in the middle of a read and a partial packet
        do_reset();
        for (int k = 0; k < 16; k++) cyc(1'b1, 4'(k), 16'(16'hB000 + k), (k == 15), 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 4'(k), 16'(16'hE000 + k), 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        chk("t6.pre_valid", 32'(rd_valid), 32'd1);
        chk("t6.pre_data", 32'(rd_data), 32'hB007);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("t6.async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 4'd0, 16'h1234, 1'b1, 1'b0);
        chk("t6.cnt", 32'(wr_packets), 32'd1);
        cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
        chk("t6.valid", 32'(rd_valid), 32'd1);
        chk("t6.data", 32'(rd_data), 32'h1234);
        chk("t6.eop", 32'(rd_eop), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_512x16_wr_offset.md
Name: fifo_512x16_wr_offset

Overview:
Single-clock 512x16 packet buffer that assembles 16-word packets from randomly ordered word writes and dequeues them in order, one word at a time.
- Write side: a producer scatters words into the packet under assembly at arbitrary in-packet offsets, then commits the packet with an end-of-packet strobe.
- Read side: committed packets drain linearly, offset 0..15, in commit order.
- Sits between a network/DMA producer that fills packets out of order and a streaming consumer.

Parameters:
- N_LOG, 5, log2 of packet slots (32 slots of 16 words = 512 words).
- DW, 16, data width in bits.

Ports:
- clk  in  1  single clock for both sides.
- rst  in  1  asynchronous, active-high reset.
- i_wr_data  in  16  word to write.
- i_wr_offset  in  4  in-packet word offset of the write.
- i_wr_en  in  1  write strobe.
- i_wr_eop  in  1  commit the packet under assembly.
- o_full  out  1  no free slot; writes and commits are ignored.
- o_wr_packets  out  6  number of committed, unread packets (0..32).
- i_rd_en  in  1  dequeue one word.
- o_rd_data  out  16  dequeued word, valid when o_rd_valid.
- o_rd_valid  out  1  o_rd_data valid this cycle.
- o_rd_eop  out  1  o_rd_data is word 15 of its packet; qualified by o_rd_valid.
- o_empty  out  1  no committed packet to read.

Behaviour:
- Reset (async, rst=1) clears:
  - wr_ptr, rd_ptr (5b) and rd_offset (4b).
  - pkt_cnt (6b) and rd_valid.
- Output values during and after reset:
  - o_full=0, o_empty=1, o_wr_packets=0, o_rd_valid=0, o_rd_eop=0.
  - o_rd_data is don't-care.
- Memory contents are not cleared.
- A reset mid-operation discards the partial packet under assembly and all unread packets.
- Derived flags:
  - o_full = (pkt_cnt == 32).
  - o_empty = (pkt_cnt == 0).
  - o_wr_packets = pkt_cnt.
- Write:
  - mem_wr_en = i_wr_en & ~o_full.
  - Address = {wr_ptr, i_wr_offset}.
  - Repeated writes to the same offset: the last write wins.
  - Offsets never written within a packet read back stale data; this is not flagged.
- Commit:
  - wr_commit = i_wr_eop & ~o_full.
  - wr_ptr increments with 5-bit wrap (31 -> 0).
  - If i_wr_en and i_wr_eop are asserted in the same cycle, the word lands in the current packet before the pointer advances.
  - i_wr_eop with no prior writes still commits a packet (all stale data).
- Read:
  - rd_fire = i_rd_en & ~o_empty.
  - Synchronous memory read at address {rd_ptr, rd_offset}.
  - rd_offset increments with 4-bit wrap.
  - Latency 1: o_rd_valid=1 and o_rd_data are presented the cycle after rd_fire.
  - o_rd_eop is registered alongside o_rd_valid and equals (rd_offset == 15) at fire time.
  - i_rd_en while empty is ignored; o_rd_valid=0 next cycle.
  - o_rd_data holds its last value when o_rd_valid=0.
- Free: a rd_fire with rd_offset==15 increments rd_ptr (wrap) and marks the packet freed.
- pkt_cnt update:
  - +1 on wr_commit only.
  - -1 on free only.
  - Unchanged when both occur in the same cycle.
  - Never exceeds 32 and never underflows.
- Visibility:
  - A commit in cycle N deasserts o_empty in N+1.
  - A free in cycle N deasserts o_full in N+1.
  - There is no same-cycle bypass.
- The slot being read never equals the slot being assembled, because pkt_cnt<32 whenever writes are accepted. Read and write therefore never touch the same address in the same cycle.

Decomposition:
- Shared package constants:
  - PKT_WORDS=16 and PKT_LOG=4.
  - FIFO_DW=16.
  - Slot-count width derived as N_LOG+1.
- Sub-module: xil_mem_dp_512x16.
  - Port 0: write-only, clk, i_wen0={2{mem_wr_en}}.
  - Port 1: read-only, clk, i_en1=rd_fire, i_wen1=0.
- Pointer, offset and count logic stay inline.

Test Plan:
- Reset, then write offsets 15..0 in descending order with data 0xA000+offset, then i_wr_eop. Expect:
  - o_empty falls one cycle later and o_wr_packets=1.
  - 16 reads return 0xA000..0xA00F in order.
  - o_rd_eop only with 0xA00F.
  - Afterwards o_empty=1 and o_wr_packets=0.
- Same cycle i_wr_en=1, i_wr_offset=15, i_wr_data=0x55AA, i_wr_eop=1 -> word 15 of that packet reads back as 0x55AA and pkt_cnt=1.
- Commit 32 packets without reading. Expect:
  - o_full=1 and o_wr_packets=32.
  - A further write plus eop is ignored: count stays 32 and slot 0 is not corrupted.
  - After one full packet is read, o_full=0 the cycle after the word-15 fire.
- With pkt_cnt=3, commit a packet in the same cycle as the word-15 read of the oldest packet -> o_wr_packets stays 3.
- Run 40 packets through continuously with concurrent writes and reads so wr_ptr and rd_ptr wrap past 31 -> data matches a scoreboard in commit order with no loss or duplication.
- Assert rst asynchronously mid-packet (offset 7 read, 5 words written) -> outputs return to reset values immediately and the next committed packet reads from offset 0 of slot 0.
